m_csr_trap_unit: RTL and testbench
==================================

// Module: m_csr_trap_unit
// PURPOSE
//  Machine-mode Zicsr CSR file and trap sequencer for the Linux-capable core.
//  Consumes csr_ops/sys_ops/exc_* produced by the ZICSR control unit.
//  Executes CSR read-modify-write, ECALL/EBREAK/MRET/WFI, synchronous exceptions and M-mode interrupts.
//  Drives redirect target, privilege mode and WFI stall back to fetch and decode.
// PARAMETERS
//  XLEN         32            datapath/CSR width (32 or 64)
//  MTVEC_RESET  'h0000_0000   mtvec value after reset
//  HART_ID      0             value returned by mhartid
//  MISA_VAL     'h4000_1100   read-only misa (RV32IM)
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous reset, active-high
//  valid        in   1     instruction at this stage retires this cycle
//  pc           in   XLEN  PC of that instruction
//  csr_ops      in   2     00 none, 01 write, 10 set, 11 clear
//  csr_addr     in   12    CSR address
//  csr_wdata    in   XLEN  rs1 value or zero-extended zimm
//  csr_rdata    out  XLEN  old CSR value (combinational)
//  sys_ops      in   3     000 none, 001 ECALL, 010 EBREAK, 011 MRET, 100 WFI
//  exc_req      in   1     upstream synchronous exception
//  exc_code     in   4     cause for exc_req
//  exc_tval     in   XLEN  faulting address/instruction for mtval
//  irq_ext/irq_timer/irq_sw in 1 each  level interrupt lines
//  trap_taken   out  1     redirect fetch this cycle (trap or MRET)
//  trap_target  out  XLEN  redirect PC
//  stall        out  1     pipeline hold while in WFI
//  priv_mode    out  2     current privilege (11 M, 00 U)
// BEHAVIOUR
//  - Reset: priv=M, mstatus/mie/mepc/mcause/mtval/mscratch=0, mtvec=MTVEC_RESET, FSM=RUN; trap_taken=0, stall=0.
//  - CSRs: mstatus(MIE b3, MPIE b7, MPP b12:11), mie, mip(RO: MEIP b11, MTIP b7, MSIP b3), mtvec, mscratch, mepc, mcause, mtval, misa, mhartid.
//  - Reads combinational; writes at clk edge. set: old|wdata; clear: old&~wdata. Unimplemented address reads 0.
//  - Illegal (cause 2, mtval=0): csr_ops=01 to addr[11:10]==11; any CSR access with addr[9:8]>priv; MRET with priv!=M.
//  - mepc[1:0] forced 0; mtvec[1:0]=mode (00 direct, 01 vectored, 1x stored as 00).
//  - Events, all qualified by valid. Priority: exc_req > illegal > ECALL/EBREAK > interrupt > MRET > CSR write.
//  - Interrupt pending = mip & mie & {MIE}. Order: MEI(11) > MSI(3) > MTI(7).
//  - ECALL cause = 8 in U, 11 in M; EBREAK cause 3, mtval=pc.
//  - Trap (same-cycle trap_taken=1, state at edge):
//    mepc<=pc; mcause<={irq,cause}; mtval<=tval or 0; MPIE<=MIE; MIE<=0; MPP<=priv; priv<=M.
//    The CSR write of the trapping instruction is suppressed.
//  - trap_target: direct -> mtvec base; vectored interrupt -> base + 4*cause; exceptions always use base.
//  - MRET: trap_taken=1, target=mepc; priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=U.
//  - FSM RUN/WFI:
//    RUN --WFI retires--> WFI (stall=1 from next cycle).
//    WFI --(mip&mie)!=0--> RUN. Exit ignores MIE. If MIE=1, the interrupt trap is taken with mepc=pc+4.
//    WFI entered with an interrupt already pending: no stall cycle.
//    rst in WFI -> RUN.
//  - Simultaneous mstatus write and trap: trap update wins.
//  - mip sampled from the irq_* lines each cycle, no latching.
// CONFIGURATION
//  ZICSR_COUNTERS_EN defined:
//    64-bit mcycle (+1 every cycle) and minstret (+1 per valid non-trapping retire).
//    Addresses B00/B02, high halves B80/B82 when XLEN=32; RO aliases C00/C02/C80/C82.
//    CSR write beats increment in the same cycle; reset to 0.
//  Not defined: those addresses read 0, writes ignored, not illegal.
// TESTING
//  - Reset, read misa/mtvec -> MISA_VAL, MTVEC_RESET; priv=11; trap_taken=0.
//  - CSRRS mstatus wdata=8, then CSRRC wdata=8 -> rdata 0 then 8; final MIE=0.
//  - priv=M, ECALL at pc=0x100, mtvec=0x200 -> trap_taken, target 0x200, mcause=11, mepc=0x100, MPP=11, MIE=0.
//  - mtvec=0x301, mie=0x80, MIE=1, irq_timer=1 -> target 0x31C, mcause=0x8000_0007; MRET -> target=mepc, MIE=1.
//  - WFI with MIE=0, mie=0x800: stall=1 for 5 cycles; irq_ext=1 -> stall=0 next cycle, no trap.
//  - After MRET to U (MPP=00), CSRRW mscratch -> cause 2 trap, CSR unchanged.
//  - COUNTERS_EN: mcycle delta 10 over 10 cycles; write 0xFFFF_FFFF to B00 -> carry into B80.

Source files
------------

// File: rtl/m_csr_trap_unit_if.sv
// Bundle between the retire stage, fetch/decode and the machine-mode CSR/trap unit.
// valid qualifies every retire-side input for exactly one cycle; there is no ready because the unit accepts every retiring instruction, and stall is the only back-pressure.
interface m_csr_trap_unit_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic [XLEN-1:0] pc;
   logic [1:0]      csr_ops;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic [2:0]      sys_ops;
   logic            exc_req;
   logic [3:0]      exc_code;
   logic [XLEN-1:0] exc_tval;
   logic            irq_ext;
   logic            irq_timer;
   logic            irq_sw;
   logic            trap_taken;
   logic [XLEN-1:0] trap_target;
   logic            stall;
   logic [1:0]      priv_mode;
   logic            wfi_state;

   modport master (
      output valid, pc, csr_ops, csr_addr, csr_wdata, sys_ops, exc_req, exc_code, exc_tval,
             irq_ext, irq_timer, irq_sw,
      input  csr_rdata, trap_taken, trap_target, stall, priv_mode, wfi_state
   );

   modport slave (
      input  valid, pc, csr_ops, csr_addr, csr_wdata, sys_ops, exc_req, exc_code, exc_tval,
             irq_ext, irq_timer, irq_sw,
      output csr_rdata, trap_taken, trap_target, stall, priv_mode, wfi_state
   );
endinterface

// File: rtl/m_csr_trap_unit.sv
// Machine-mode Zicsr CSR file with trap/MRET/WFI sequencing and interrupt arbitration.
// Define ZICSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their read-only aliases.
module m_csr_trap_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MISA_VAL    = XLEN'(32'h4000_1100)
) (
   input logic              clk,
   input logic              rst,
   m_csr_trap_unit_if.slave bus
);
   localparam logic [1:0]      PRIV_M     = 2'b11;
   localparam logic [1:0]      PRIV_U     = 2'b00;
   localparam logic [2:0]      SYS_ECALL  = 3'b001;
   localparam logic [2:0]      SYS_EBREAK = 3'b010;
   localparam logic [2:0]      SYS_MRET   = 3'b011;
   localparam logic [2:0]      SYS_WFI    = 3'b100;
   localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);

   typedef enum logic {S_RUN = 1'b0, S_WFI = 1'b1} state_e;

   state_e          state_q;
   logic            stall_q;
   logic [1:0]      priv_q;
   logic            mstatus_mie_q;
   logic            mstatus_mpie_q;
   logic [1:0]      mstatus_mpp_q;
   logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, wfi_pc_q;

   logic [XLEN-1:0] mstatus, mip, csr_old, csr_new, irq_pend;
   logic [XLEN-1:0] trap_tval, trap_pc, trap_mcause, tvec_base, target;
   logic [3:0]      irq_cause, trap_cause;
   logic            csr_illegal, wake, irq_any;
   logic            trap, trap_irq, do_mret, do_wfi, do_csr_wr;

`ifdef ZICSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d, csr_new64;
   logic        retire;
`endif

   always_comb begin
      mstatus        = '0;
      mstatus[3]     = mstatus_mie_q;
      mstatus[7]     = mstatus_mpie_q;
      mstatus[12:11] = mstatus_mpp_q;
      mip            = '0;
      mip[11]        = bus.irq_ext;
      mip[7]         = bus.irq_timer;
      mip[3]         = bus.irq_sw;
   end

   always_comb begin
      csr_old = '0;
      case (bus.csr_addr)
         12'h300: csr_old = mstatus;
         12'h301: csr_old = MISA_VAL;
         12'h304: csr_old = mie_q;
         12'h305: csr_old = mtvec_q;
         12'h340: csr_old = mscratch_q;
         12'h341: csr_old = mepc_q;
         12'h342: csr_old = mcause_q;
         12'h343: csr_old = mtval_q;
         12'h344: csr_old = mip;
         12'hF14: csr_old = HART_ID;
`ifdef ZICSR_COUNTERS_EN
         12'hB00, 12'hC00: csr_old = mcycle_q[XLEN-1:0];
         12'hB02, 12'hC02: csr_old = minstret_q[XLEN-1:0];
         12'hB80, 12'hC80: if (XLEN == 32) csr_old = XLEN'(mcycle_q[63:32]);
         12'hB82, 12'hC82: if (XLEN == 32) csr_old = XLEN'(minstret_q[63:32]);
`endif
         default: csr_old = '0;
      endcase
      case (bus.csr_ops)
         2'b01:   csr_new = bus.csr_wdata;
         2'b10:   csr_new = csr_old | bus.csr_wdata;
         2'b11:   csr_new = csr_old & ~bus.csr_wdata;
         default: csr_new = csr_old;
      endcase
   end

   assign irq_pend  = mip & mie_q & {XLEN{mstatus_mie_q}};
   assign irq_any   = |irq_pend;
   assign wake      = |(mip & mie_q);
   assign irq_cause = irq_pend[11] ? 4'd11 : (irq_pend[3] ? 4'd3 : 4'd7);
   assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

   assign csr_illegal = (bus.csr_ops == 2'b01 && bus.csr_addr[11:10] == 2'b11) ||
                        (bus.csr_ops != 2'b00 && bus.csr_addr[9:8] > priv_q) ||
                        (bus.sys_ops == SYS_MRET && priv_q != PRIV_M);

   // Event arbitration; a sleeping WFI is woken by an enabled interrupt even with valid low.
   always_comb begin
      trap       = 1'b0;
      trap_irq   = 1'b0;
      trap_cause = 4'd0;
      trap_tval  = '0;
      trap_pc    = bus.pc;
      do_mret    = 1'b0;
      do_wfi     = 1'b0;
      do_csr_wr  = 1'b0;
      if (state_q == S_WFI) begin
         if (irq_any) begin
            trap       = 1'b1;
            trap_irq   = 1'b1;
            trap_cause = irq_cause;
            trap_pc    = wfi_pc_q + XLEN'(4);
         end
      end else if (bus.valid) begin
         if (bus.exc_req) begin
            trap       = 1'b1;
            trap_cause = bus.exc_code;
            trap_tval  = bus.exc_tval;
         end else if (csr_illegal) begin
            trap       = 1'b1;
            trap_cause = 4'd2;
         end else if (bus.sys_ops == SYS_ECALL) begin
            trap       = 1'b1;
            trap_cause = (priv_q == PRIV_M) ? 4'd11 : 4'd8;
         end else if (bus.sys_ops == SYS_EBREAK) begin
            trap       = 1'b1;
            trap_cause = 4'd3;
            trap_tval  = bus.pc;
         end else if (irq_any) begin
            trap       = 1'b1;
            trap_irq   = 1'b1;
            trap_cause = irq_cause;
         end else if (bus.sys_ops == SYS_MRET) begin
            do_mret = 1'b1;
         end else begin
            // A set/clear with an empty mask changes nothing, so it must not stop the counters.
            do_csr_wr = (bus.csr_ops == 2'b01) || (bus.csr_ops != 2'b00 && bus.csr_wdata != '0);
            do_wfi    = (bus.sys_ops == SYS_WFI);
         end
      end
      trap_mcause           = '0;
      trap_mcause[XLEN-1]   = trap_irq;
      trap_mcause[3:0]      = trap_cause;
      if (do_mret)
         target = mepc_q;
      else if (trap_irq && mtvec_q[1:0] == 2'b01)
         target = tvec_base + {{(XLEN-6){1'b0}}, trap_cause, 2'b00};
      else
         target = tvec_base;
   end

`ifdef ZICSR_COUNTERS_EN
   always_comb begin
      csr_new64  = 64'(csr_new);
      retire     = bus.valid && (state_q == S_RUN) && !trap;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + (retire ? 64'd1 : 64'd0);
      if (do_csr_wr) begin
         case (bus.csr_addr)
            12'hB00: mcycle_d   = (XLEN == 32) ? {mcycle_q[63:32], csr_new64[31:0]} : csr_new64;
            12'hB02: minstret_d = (XLEN == 32) ? {minstret_q[63:32], csr_new64[31:0]} : csr_new64;
            12'hB80: if (XLEN == 32) mcycle_d = {csr_new64[31:0], mcycle_q[31:0]};
            12'hB82: if (XLEN == 32) minstret_d = {csr_new64[31:0], minstret_q[31:0]};
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_RUN;
         stall_q        <= 1'b0;
         priv_q         <= PRIV_M;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mstatus_mpp_q  <= 2'b00;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         wfi_pc_q       <= '0;
`ifdef ZICSR_COUNTERS_EN
         mcycle_q       <= '0;
         minstret_q     <= '0;
`endif
      end else begin
`ifdef ZICSR_COUNTERS_EN
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
`endif
         if (trap) begin
            mepc_q         <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q       <= trap_mcause;
            mtval_q        <= trap_tval;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpp_q  <= priv_q;
            priv_q         <= PRIV_M;
         end else if (do_mret) begin
            priv_q         <= mstatus_mpp_q;
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            mstatus_mpp_q  <= PRIV_U;
         end else if (do_csr_wr) begin
            case (bus.csr_addr)
               12'h300: begin
                  mstatus_mie_q  <= csr_new[3];
                  mstatus_mpie_q <= csr_new[7];
                  mstatus_mpp_q  <= (csr_new[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
               end
               12'h304: mie_q      <= csr_new & MIE_MASK;
               12'h305: mtvec_q    <= {csr_new[XLEN-1:2], 1'b0, (csr_new[1:0] == 2'b01)};
               12'h340: mscratch_q <= csr_new;
               12'h341: mepc_q     <= {csr_new[XLEN-1:2], 2'b00};
               12'h342: mcause_q   <= csr_new;
               12'h343: mtval_q    <= csr_new;
               default: ;
            endcase
         end
         case (state_q)
            S_RUN: begin
               if (do_wfi && !wake) begin
                  state_q  <= S_WFI;
                  stall_q  <= 1'b1;
                  wfi_pc_q <= bus.pc;
               end
            end
            S_WFI: begin
               if (wake) begin
                  state_q <= S_RUN;
                  stall_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_RUN;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.csr_rdata   = csr_old;
   assign bus.trap_taken  = trap | do_mret;
   assign bus.trap_target = target;
   assign bus.stall       = stall_q;
   assign bus.priv_mode   = priv_q;
   assign bus.wfi_state   = (state_q == S_WFI);
endmodule

// File: tb/tb_m_csr_trap_unit.sv
// Directed bench for m_csr_trap_unit: a driver pushes expected responses, a negedge monitor pops and compares.
module tb_m_csr_trap_unit;
  localparam int XLEN = 32;
  localparam logic [2:0] ECALL = 3'b001, EBREAK = 3'b010, MRET = 3'b011, WFI = 3'b100;
  localparam logic [1:0] M = 2'b11, U = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m_csr_trap_unit_if #(.XLEN(XLEN)) bus();

  m_csr_trap_unit #(
    .XLEN(XLEN), .MTVEC_RESET(32'h0000_0040), .HART_ID(32'h0000_0005), .MISA_VAL(32'h4000_1100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] rd;
    logic        trap;
    logic [31:0] tgt;
    logic        chk_stall;
    logic        stall;
    logic        chk_priv;
    logic [1:0]  priv;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        strobe = 1'b0;
  logic [31:0] pc_r = 32'h0000_1000;

  // ---------------- driver tasks ----------------
  task automatic cyc_begin();
    @(posedge clk);
    #1;
    bus.valid = 1'b0; bus.csr_ops = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = '0;
    bus.sys_ops = 3'b000; bus.exc_req = 1'b0; bus.exc_code = 4'd0; bus.exc_tval = '0;
    strobe = 1'b0;
  endtask

  task automatic push(input string nm, input logic chk_rd, input logic [31:0] rd, input logic trap,
                      input logic [31:0] tgt, input logic chk_stall, input logic stall,
                      input logic chk_priv, input logic [1:0] priv);
    exp_t e;
    e.name = nm; e.chk_rd = chk_rd; e.rd = rd; e.trap = trap; e.tgt = tgt;
    e.chk_stall = chk_stall; e.stall = stall; e.chk_priv = chk_priv; e.priv = priv;
    exp_q.push_back(e);
    strobe = 1'b1;
  endtask

  task automatic do_csr(input string nm, input logic [1:0] ops, input logic [11:0] addr,
                        input logic [31:0] wd, input logic chk_rd, input logic [31:0] rd,
                        input logic trap, input logic [31:0] tgt);
    cyc_begin();
    bus.valid = 1'b1; bus.pc = pc_r; bus.csr_ops = ops; bus.csr_addr = addr; bus.csr_wdata = wd;
    push(nm, chk_rd, rd, trap, tgt, 1'b0, 1'b0, 1'b0, 2'b00);
    pc_r = pc_r + 32'd4;
  endtask

  task automatic rd_csr(input string nm, input logic [11:0] addr, input logic [31:0] exp_val);
    do_csr(nm, 2'b10, addr, 32'h0, 1'b1, exp_val, 1'b0, 32'h0);
  endtask

  task automatic do_sys(input string nm, input logic [2:0] sys, input logic [31:0] pc,
                        input logic trap, input logic [31:0] tgt);
    cyc_begin();
    bus.valid = 1'b1; bus.pc = pc; bus.sys_ops = sys;
    push(nm, 1'b0, 32'h0, trap, tgt, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_exc(input string nm, input logic [3:0] code, input logic [31:0] tval,
                        input logic [31:0] pc, input logic [31:0] tgt);
    cyc_begin();
    bus.valid = 1'b1; bus.pc = pc; bus.sys_ops = ECALL;
    bus.exc_req = 1'b1; bus.exc_code = code; bus.exc_tval = tval;
    push(nm, 1'b0, 32'h0, 1'b1, tgt, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic idle_chk(input string nm, input logic trap, input logic [31:0] tgt,
                          input logic stall, input logic [1:0] priv);
    cyc_begin();
    push(nm, 1'b0, 32'h0, trap, tgt, 1'b1, stall, 1'b1, priv);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc_begin();
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output observed with empty expected queue (got 1 expected 0)");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "trap_taken", 32'(bus.trap_taken), 32'(e.trap));
        if (e.chk_rd)    cmp(e.name, "csr_rdata", bus.csr_rdata, e.rd);
        if (e.trap)      cmp(e.name, "trap_target", bus.trap_target, e.tgt);
        if (e.chk_stall) cmp(e.name, "stall", 32'(bus.stall), 32'(e.stall));
        if (e.chk_priv)  cmp(e.name, "priv_mode", 32'(bus.priv_mode), 32'(e.priv));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cyc;
    bus.valid = 1'b0; bus.pc = '0; bus.csr_ops = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = '0;
    bus.sys_ops = 3'b000; bus.exc_req = 1'b0; bus.exc_code = 4'd0; bus.exc_tval = '0;
    bus.irq_ext = 1'b0; bus.irq_timer = 1'b0; bus.irq_sw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    idle_chk("reset", 1'b0, 32'h0, 1'b0, M);
    rd_csr("misa", 12'h301, 32'h4000_1100);
    rd_csr("mtvec_rst", 12'h305, 32'h0000_0040);
    rd_csr("mhartid", 12'hF14, 32'h0000_0005);
    rd_csr("mstatus_rst", 12'h300, 32'h0);

    // set / clear
    do_csr("csrrs_mstatus", 2'b10, 12'h300, 32'h8, 1'b1, 32'h0, 1'b0, 32'h0);
    do_csr("csrrc_mstatus", 2'b11, 12'h300, 32'h8, 1'b1, 32'h8, 1'b0, 32'h0);
    rd_csr("mstatus_clr", 12'h300, 32'h0);

    // ECALL from M
    do_csr("mtvec_wr", 2'b01, 12'h305, 32'h200, 1'b1, 32'h40, 1'b0, 32'h0);
    do_sys("ecall_m", ECALL, 32'h100, 1'b1, 32'h200);
    rd_csr("ecall_mcause", 12'h342, 32'hB);
    rd_csr("ecall_mepc", 12'h341, 32'h100);
    rd_csr("ecall_mstatus", 12'h300, 32'h1800);
    rd_csr("ecall_mtval", 12'h343, 32'h0);

    // vectored timer interrupt, then MRET
    do_csr("mtvec_vec", 2'b01, 12'h305, 32'h301, 1'b1, 32'h200, 1'b0, 32'h0);
    do_csr("mie_wr", 2'b01, 12'h304, 32'h80, 1'b1, 32'h0, 1'b0, 32'h0);
    do_csr("mie_en", 2'b10, 12'h300, 32'h8, 1'b1, 32'h1800, 1'b0, 32'h0);
    cyc_begin(); bus.irq_timer = 1'b1;
    pc_r = 32'h140;
    do_csr("irq_timer", 2'b01, 12'h340, 32'h55, 1'b1, 32'h0, 1'b1, 32'h31C);
    cyc_begin(); bus.irq_timer = 1'b0;
    rd_csr("irq_mcause", 12'h342, 32'h8000_0007);
    rd_csr("irq_mepc", 12'h341, 32'h140);
    rd_csr("irq_mscratch", 12'h340, 32'h0);
    rd_csr("irq_mstatus", 12'h300, 32'h1880);
    do_sys("mret_m", MRET, 32'h160, 1'b1, 32'h140);
    rd_csr("mret_mstatus", 12'h300, 32'h88);
    idle_chk("mret_priv", 1'b0, 32'h0, 1'b0, M);

    // EBREAK (exception uses base even when vectored)
    do_sys("ebreak", EBREAK, 32'h180, 1'b1, 32'h300);
    rd_csr("ebreak_mcause", 12'h342, 32'h3);
    rd_csr("ebreak_mtval", 12'h343, 32'h180);
    rd_csr("ebreak_mstatus", 12'h300, 32'h1880);

    // upstream exception beats ECALL
    do_exc("exc_prio", 4'd5, 32'hDEAD, 32'h1C0, 32'h300);
    rd_csr("exc_mcause", 12'h342, 32'h5);
    rd_csr("exc_mtval", 12'h343, 32'hDEAD);
    rd_csr("exc_mepc", 12'h341, 32'h1C0);

    // write to read-only address
    do_csr("ro_write", 2'b01, 12'hC00, 32'h1, 1'b0, 32'h0, 1'b1, 32'h300);
    rd_csr("ro_mcause", 12'h342, 32'h2);
    rd_csr("ro_mtval", 12'h343, 32'h0);

    // WFI with MIE=0: stall, wake without trap
    do_csr("mie_ext", 2'b01, 12'h304, 32'h800, 1'b1, 32'h80, 1'b0, 32'h0);
    do_sys("wfi", WFI, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) idle_chk("wfi_stall", 1'b0, 32'h0, 1'b1, M);
    idle_chk("wfi_irq", 1'b0, 32'h0, 1'b1, M); bus.irq_ext = 1'b1;
    idle_chk("wfi_exit", 1'b0, 32'h0, 1'b0, M); bus.irq_ext = 1'b0;

    // WFI with MIE=1: wake trap with mepc = pc+4
    do_csr("mie_en2", 2'b10, 12'h300, 32'h8, 1'b1, 32'h1800, 1'b0, 32'h0);
    do_sys("wfi2", WFI, 32'h240, 1'b0, 32'h0);
    idle_chk("wfi2_stall", 1'b0, 32'h0, 1'b1, M);
    idle_chk("wfi2_wake", 1'b1, 32'h32C, 1'b1, M); bus.irq_ext = 1'b1;
    idle_chk("wfi2_run", 1'b0, 32'h0, 1'b0, M); bus.irq_ext = 1'b0;
    rd_csr("wfi2_mepc", 12'h341, 32'h244);
    rd_csr("wfi2_mcause", 12'h342, 32'h8000_000B);

    // WFI with interrupt already pending: no stall cycle
    do_sys("wfi_pend", WFI, 32'h280, 1'b0, 32'h0); bus.irq_ext = 1'b1;
    idle_chk("wfi_pend_nostall", 1'b0, 32'h0, 1'b0, M); bus.irq_ext = 1'b0;

    // drop to U, illegal access, illegal MRET, ECALL from U
    do_csr("mpp_clr", 2'b11, 12'h300, 32'h1800, 1'b1, 32'h1880, 1'b0, 32'h0);
    do_sys("mret_u", MRET, 32'h2C0, 1'b1, 32'h244);
    idle_chk("u_priv", 1'b0, 32'h0, 1'b0, U);
    pc_r = 32'h400;
    do_csr("u_mscratch", 2'b01, 12'h340, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h300);
    idle_chk("u_trap_priv", 1'b0, 32'h0, 1'b0, M);
    rd_csr("u_mcause", 12'h342, 32'h2);
    rd_csr("u_mscratch_kept", 12'h340, 32'h0);
    rd_csr("u_mepc", 12'h341, 32'h400);
    rd_csr("u_mstatus", 12'h300, 32'h80);
    do_sys("mret_u2", MRET, 32'h480, 1'b1, 32'h400);
    do_sys("mret_in_u", MRET, 32'h4C0, 1'b1, 32'h300);
    do_sys("mret_u3", MRET, 32'h4E0, 1'b1, 32'h4C0);
    do_sys("ecall_u", ECALL, 32'h500, 1'b1, 32'h300);
    rd_csr("ecall_u_mcause", 12'h342, 32'h8);

    // mtvec mode 1x legalises to direct; unimplemented CSR
    do_csr("mtvec_1x", 2'b01, 12'h305, 32'h203, 1'b1, 32'h301, 1'b0, 32'h0);
    rd_csr("mtvec_1x_rd", 12'h305, 32'h200);
    rd_csr("unimpl", 12'h7C0, 32'h0);

`ifdef ZICSR_COUNTERS_EN
    do_csr("mcycle_wr", 2'b01, 12'hB00, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    rd_csr("mcycle_t0", 12'hB00, 32'h100);
    idle_n(9);
    rd_csr("mcycle_t10", 12'hB00, 32'h10A);
    do_csr("mcycle_max", 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
    rd_csr("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rd_csr("mcycleh_carry", 12'hB80, 32'h1);
    rd_csr("cycle_alias", 12'hC00, 32'h1);
    do_csr("minstret_wr", 2'b01, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rd_csr("minstret_0", 12'hB02, 32'h0);
    rd_csr("instret_alias", 12'hC02, 32'h1);
    rd_csr("instreth_alias", 12'hC82, 32'h0);
`else
    rd_csr("mcycle_absent", 12'hB00, 32'h0);
    do_csr("mcycle_wr_ign", 2'b01, 12'hB00, 32'h5, 1'b1, 32'h0, 1'b0, 32'h0);
    rd_csr("mcycle_still0", 12'hB00, 32'h0);
    rd_csr("cycleh_absent", 12'hC80, 32'h0);
`endif

    cyc_begin();
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
